// File: rtl/vin_temp_monitor.sv
// Thermocouple reading monitor: samples a 12-bit reading, accepts it on two equal samples, filters it and raises an over-temperature alarm.
// Optional macro VIN_TEMP_MONITOR_AVG_EN adds a 4-tap moving average in front of temp_out.
module vin_temp_monitor #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter logic [11:0] ALARM_HIGH = 12'd1600,
  parameter logic [11:0] ALARM_LOW  = 12'd1520
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_in,
  output logic [11:0] temp_out,
  output logic        temp_strobe,
  output logic        temp_valid,
  output logic        alarm,
  output logic        fault
);

  localparam int unsigned CW         = (SAMPLE_DIV > 32'd1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 32'd1);
  localparam logic [11:0] FAULT_CODE = 12'hFFF;

  // Hysteresis rule: set at or above the high threshold, clear at or below the low one, else hold.
  function automatic logic thr_eval(input logic [11:0] value, input logic prev);
    logic res;
    if (value >= ALARM_HIGH) begin
      res = 1'b1;
    end else if (value <= ALARM_LOW) begin
      res = 1'b0;
    end else begin
      res = prev;
    end
    return res;
  endfunction

  logic [CW-1:0] r_tick_cnt;
  logic [11:0]   r_sync1;
  logic [11:0]   r_sync2;
  logic [11:0]   r_last_sample;
  logic          r_have_last;
  logic          r_acc_pend;
  logic [11:0]   r_acc_val;
  logic          r_thr_alarm;
  logic [11:0]   r_temp_out;
  logic          r_temp_strobe;
  logic          r_temp_valid;
  logic          r_alarm;
  logic          r_fault;

  logic          w_tick;
  logic          w_acc_good;
  logic          w_acc_fault;
  logic [11:0]   w_new_out;
  logic          w_thr_next;
  logic          w_unused_hi;

  assign w_unused_hi = ^temp_in[15:12];
  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_acc_good  = r_acc_pend && (r_acc_val != FAULT_CODE);
  assign w_acc_fault = r_acc_pend && (r_acc_val == FAULT_CODE);

  // Free-running sample period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Two-flop synchroniser; bus tearing is rejected later by the equal-sample rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 12'd0;
      r_sync2 <= 12'd0;
    end else begin
      r_sync1 <= temp_in[11:0];
      r_sync2 <= r_sync1;
    end
  end

  // Sample on each tick and flag an acceptance when two consecutive samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_sample <= 12'd0;
      r_have_last   <= 1'b0;
      r_acc_pend    <= 1'b0;
      r_acc_val     <= 12'd0;
    end else if (w_tick) begin
      r_last_sample <= r_sync2;
      r_have_last   <= 1'b1;
      r_acc_pend    <= r_have_last && (r_sync2 == r_last_sample);
      r_acc_val     <= r_sync2;
    end else begin
      r_acc_pend    <= 1'b0;
    end
  end

`ifdef VIN_TEMP_MONITOR_AVG_EN
  logic [11:0] r_tap [4];
  logic [13:0] r_sum;
  logic [13:0] w_sum_next;

  // First good value preloads all taps, so the sum is simply four times it.
  always_comb begin
    w_sum_next = r_sum;
    if (r_temp_valid) begin
      w_sum_next = r_sum + {2'b00, r_acc_val} - {2'b00, r_tap[3]};
    end else begin
      w_sum_next = {r_acc_val, 2'b00};
    end
  end

  assign w_new_out = w_sum_next[13:2];

  // History shift register and running sum, advanced on good acceptances only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_tap[i] <= 12'd0;
      end
      r_sum <= 14'd0;
    end else if (w_acc_good) begin
      if (r_temp_valid) begin
        r_tap[0] <= r_acc_val;
        for (int i = 1; i < 4; i++) begin
          r_tap[i] <= r_tap[i-1];
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          r_tap[i] <= r_acc_val;
        end
      end
      r_sum <= w_sum_next;
    end else begin
      r_sum <= r_sum;
    end
  end
`else
  assign w_new_out = r_acc_val;
`endif

  assign w_thr_next = thr_eval(w_new_out, r_thr_alarm);

  // Output stage: one cycle after acceptance; a fault code forces the alarm and leaves temp_out alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp_out    <= 12'd0;
      r_temp_strobe <= 1'b0;
      r_temp_valid  <= 1'b0;
      r_alarm       <= 1'b0;
      r_fault       <= 1'b0;
      r_thr_alarm   <= 1'b0;
    end else begin
      r_temp_strobe <= 1'b0;
      if (w_acc_good) begin
        r_temp_out    <= w_new_out;
        r_temp_strobe <= 1'b1;
        r_temp_valid  <= 1'b1;
        r_fault       <= 1'b0;
        r_thr_alarm   <= w_thr_next;
        r_alarm       <= w_thr_next;
      end else if (w_acc_fault) begin
        r_fault       <= 1'b1;
        r_alarm       <= 1'b1;
      end else begin
        r_alarm       <= r_alarm;
      end
    end
  end

  assign temp_out    = r_temp_out;
  assign temp_strobe = r_temp_strobe;
  assign temp_valid  = r_temp_valid;
  assign alarm       = r_alarm;
  assign fault       = r_fault;

endmodule

// File: tb/tb_vin_temp_monitor.sv
// Directed and randomized bench for vin_temp_monitor with a behavioural reference model.
module tb_vin_temp_monitor;

  logic        clk;
  logic        rst_n;
  logic [15:0] temp_in;
  logic [11:0] temp_out;
  logic        temp_strobe;
  logic        temp_valid;
  logic        alarm;
  logic        fault;

  int checks;
  int errors;

  // Reference model state
  bit   m_have_prev;
  int   m_prev;
  int   hist[$];
  int   m_out;
  bit   m_strobe;
  bit   m_valid;
  bit   m_fault;
  bit   m_alarm;
  bit   m_thr;

  vin_temp_monitor #(.SAMPLE_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .temp_in     (temp_in),
    .temp_out    (temp_out),
    .temp_strobe (temp_strobe),
    .temp_valid  (temp_valid),
    .alarm       (alarm),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have_prev = 1'b0;
    m_prev      = 0;
    hist.delete();
    m_out = 0; m_strobe = 1'b0; m_valid = 1'b0;
    m_fault = 1'b0; m_alarm = 1'b0; m_thr = 1'b0;
  endtask

  task automatic model_tick(input int v);
    bit acc;
    int sum;
    acc = m_have_prev && (v == m_prev);
    m_prev = v;
    m_have_prev = 1'b1;
    m_strobe = 1'b0;
    if (acc) begin
      if (v == 4095) begin
        m_fault = 1'b1;
        m_alarm = 1'b1;
      end else begin
        m_fault = 1'b0;
        if (!m_valid) begin
          hist = '{v, v, v, v};
        end else begin
          hist.push_back(v);
          void'(hist.pop_front());
        end
        m_valid = 1'b1;
        sum = 0;
        foreach (hist[i]) sum += hist[i];
`ifdef VIN_TEMP_MONITOR_AVG_EN
        m_out = sum / 4;
`else
        m_out = v;
`endif
        if (m_out >= 1600) m_thr = 1'b1;
        else if (m_out <= 1520) m_thr = 1'b0;
        m_alarm  = m_thr;
        m_strobe = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".strobe"}, int'(temp_strobe), int'(m_strobe));
    chk({tag, ".out"},    int'(temp_out),    m_out);
    chk({tag, ".valid"},  int'(temp_valid),  int'(m_valid));
    chk({tag, ".fault"},  int'(fault),       int'(m_fault));
    chk({tag, ".alarm"},  int'(alarm),       int'(m_alarm));
  endtask

  // Entered just after the output edge of the previous period; returns just after the next one.
  task automatic period(input logic [11:0] v, input string tag);
    temp_in = {4'($urandom_range(0, 15)), v};
    @(posedge clk); #1;
    chk({tag, ".strobe_idle"}, int'(temp_strobe), 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    model_tick(int'(v));
    check_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst.out",    int'(temp_out),    0);
    chk("rst.strobe", int'(temp_strobe), 0);
    chk("rst.valid",  int'(temp_valid),  0);
    chk("rst.fault",  int'(fault),       0);
    chk("rst.alarm",  int'(alarm),       0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] v;
    logic [11:0] lastv;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    temp_in = 16'd0;
    model_reset();

    do_reset();
    @(posedge clk); #1;
    chk("post_rst.strobe", int'(temp_strobe), 0);

    // Alternating samples never accept
    for (int i = 0; i < 6; i++) period((i % 2 == 0) ? 12'd100 : 12'd101, "alt");
    chk("alt.valid_low", int'(temp_valid), 0);

    // Steady 400
    for (int i = 0; i < 4; i++) period(12'd400, "hold400");
    chk("hold400.out", int'(temp_out), 400);

`ifdef VIN_TEMP_MONITOR_AVG_EN
    // Step response of the moving average
    period(12'd800, "step.discard");
    chk("step.discard.out", int'(temp_out), 400);
    period(12'd800, "step1"); chk("step1.out_c", int'(temp_out), 500);
    period(12'd800, "step2"); chk("step2.out_c", int'(temp_out), 600);
    period(12'd800, "step3"); chk("step3.out_c", int'(temp_out), 700);
    period(12'd800, "step4"); chk("step4.out_c", int'(temp_out), 800);
`endif

    // Ramp through the alarm thresholds
    for (int i = 0; i < 6; i++) period(12'd1500, "ramp1500");
    for (int i = 0; i < 6; i++) period(12'd1600, "ramp1600");
    chk("ramp.alarm_set", int'(alarm), 1);
    for (int i = 0; i < 6; i++) period(12'd1560, "ramp1560");
    chk("ramp.alarm_hold", int'(alarm), 1);
    for (int i = 0; i < 6; i++) period(12'd1520, "ramp1520");
    chk("ramp.alarm_clear", int'(alarm), 0);

    // Stuck sensor then recovery
    for (int i = 0; i < 3; i++) period(12'hFFF, "fault");
    chk("fault.flag", int'(fault), 1);
    chk("fault.alarm", int'(alarm), 1);
    for (int i = 0; i < 3; i++) period(12'd500, "recover");
    chk("recover.fault", int'(fault), 0);

    // Largest legal value: no sum overflow
    for (int i = 0; i < 6; i++) period(12'hFFE, "max");
    chk("max.out", int'(temp_out), 4094);

    // Randomized periods
    lastv = 12'd0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        v = lastv;
      end else begin
        case ($urandom_range(0, 3))
          0: v = 12'($urandom_range(0, 4094));
          1: v = 12'($urandom_range(1450, 1700));
          2: v = 12'hFFF;
          default: v = 12'($urandom_range(0, 4095));
        endcase
      end
      lastv = v;
      period(v, "rand");
    end

    // Mid-period reset with alarm raised, then first-tick timing
    for (int i = 0; i < 3; i++) period(12'hFFF, "pre_rst");
    chk("pre_rst.alarm", int'(alarm), 1);
    temp_in = 16'd700;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk("rst_timing.strobe_low", int'(temp_strobe), 0);
    end
    @(posedge clk); #1;
    model_tick(700);
    model_tick(700);
    check_all("rst_timing");
    chk("rst_timing.out_c", int'(temp_out), 700);
    for (int i = 0; i < 3; i++) period(12'd700, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vin_temp_monitor.md
VIN_TEMP_MONITOR -- requirements
Module: vin_temp_monitor

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000: clk cycles between input samples, legal range 2 or more.
REQ-002 Parameter ALARM_HIGH, default 12'd1600: alarm set threshold, 400.00 C in 0.25 C LSB.
REQ-003 Parameter ALARM_LOW, default 12'd1520: alarm clear threshold; ALARM_LOW < ALARM_HIGH.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 temp_in  input  16  raw reading from the upstream MAX6675 reader; bits [11:0] are the 0.25 C count and bits [15:12] are ignored; driven from a derived clock, so treat as asynchronous.
REQ-007 temp_out  output  12  filtered temperature, 0.25 C LSB.
REQ-008 temp_strobe  output  1  one-cycle pulse when temp_out is updated.
REQ-009 temp_valid  output  1  high once the first good reading has been accepted.
REQ-010 alarm  output  1  over-temperature alarm with hysteresis; fail-safe high on fault.
REQ-011 fault  output  1  sensor fault (reading stuck at 12'hFFF).

Function
REQ-012 Tick counter shall count 0..SAMPLE_DIV-1 and wrap; a tick occurs on the cycle the counter equals SAMPLE_DIV-1.
REQ-013 Each tick shall register cur = temp_in[11:0] into last_sample.
REQ-014 A tick where cur == last_sample (two consecutive equal samples) shall be an acceptance; a tick with unequal samples shall be discarded with no output change.
REQ-015 Accepted value 12'hFFF shall set fault and shall not enter the filter; an accepted value other than 12'hFFF shall clear fault.
REQ-016 Latency: acceptance at clock edge k; temp_out, temp_strobe, fault-driven alarm and threshold alarm all update at edge k+1.
REQ-017 temp_strobe shall pulse for exactly one cycle for each non-fault acceptance, and never for fault acceptances.
REQ-018 temp_valid shall set on the first non-fault acceptance and hold until reset.
REQ-019 Threshold alarm: set when the new temp_out >= ALARM_HIGH; clear when the new temp_out <= ALARM_LOW; otherwise hold.
REQ-020 While fault = 1, alarm shall be 1 regardless of temp_out.
REQ-021 After fault clears, alarm shall re-evaluate against the new temp_out at the same edge.
REQ-022 Arithmetic shall be unsigned; the filter sum shall be 14 bits wide; temp_out shall be sum[13:2] (truncating); there shall be no overflow at 4 x 12'hFFE.
REQ-023 Ticks shall continue unaffected by acceptance, fault or alarm state.

Reset
REQ-024 When rst_n = 0, the block shall asynchronously clear:
- the tick counter and last_sample;
- the filter history;
- temp_out = 0, temp_strobe = 0, temp_valid = 0, fault = 0, alarm = 0.
REQ-025 Reset asserted mid-period shall discard any pending acceptance.
REQ-026 After release, the first tick shall occur SAMPLE_DIV cycles later.
REQ-027 Acceptance requires two ticks after reset, so the first possible strobe comes on tick 2 + 1 cycle.

Configuration
REQ-028 Macro VIN_TEMP_MONITOR_AVG_EN, when defined, shall compile in a 4-tap moving average with this behaviour:
- history shift register of 4 x 12 bits plus the sum;
- temp_out = (sum of the last 4 non-fault accepted values) >> 2;
- the first non-fault acceptance after reset preloads all 4 taps with that value, so there is no startup ramp.
REQ-029 When the macro is undefined, no history registers shall exist and temp_out shall equal the latest non-fault accepted value; latency shall be unchanged (edge k+1).

Verification
REQ-030 SAMPLE_DIV=4, temp_in held at 12'd400 -> first strobe 1 cycle after the 2nd tick; temp_out=400; temp_valid=1; alarm=0.
REQ-031 temp_in alternating 100/101 on every tick -> no acceptance, no strobe, temp_valid stays 0.
REQ-032 AVG_EN, after settling at 400, step to 800 held -> temp_out 500, 600, 700, 800 on successive strobes (first post-step tick discarded).
REQ-033 Ramp through 1600 then down -> alarm sets when temp_out = 1600, holds at 1560, clears at 1520.
REQ-034 temp_in = 12'hFFF held -> fault=1, alarm=1, no strobe, temp_out unchanged; return to 500 held -> fault=0, strobe, alarm per threshold.
REQ-035 rst_n pulsed low for 1 cycle mid-period with alarm=1 -> all outputs 0 immediately; next tick exactly SAMPLE_DIV cycles after release.
